// File: rtl/cim_gemm_engine.sv
// Compute-in-memory GEMM macro: OUT_PAR byte-wide weight banks, each feeding an IN_PAR-lane
// dot product, with a job sequencer that accumulates, quantises and streams one code per channel.
module cim_gemm_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int IN_PREC    = 4,
  parameter int IN_PAR     = 8,
  parameter int OUT_PAR    = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int ADC_MSB    = 13,
  parameter int ADC_PREC   = 6,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic                                  wr_valid_i,
  output logic                                  wr_ready_o,
  input  logic [ADDR_WIDTH-1:0]                 wr_addr_i,
  input  logic [31:0]                           wr_data_i,
  input  logic                                  start_valid_i,
  output logic                                  start_ready_o,
  input  logic [ADDR_WIDTH-$clog2(OUT_PAR)-1:0] start_base_i,
  input  logic [LEN_WIDTH-1:0]                  start_len_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [IN_PAR*IN_PREC-1:0]             in_data_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [31:0]                           out_data_o,
  output logic [$clog2(OUT_PAR)-1:0]            out_chan_o,
  output logic                                  out_last_o,
  output logic                                  busy_o
);

  localparam int RAM_DEPTH = 2**ADDR_WIDTH;
  localparam int CW        = $clog2(OUT_PAR);
  localparam int RW        = ADDR_WIDTH - CW;
  localparam int PSUM_W    = DATA_WIDTH + IN_PREC + $clog2(IN_PAR);
  localparam int SHIFT     = ADC_MSB - ADC_PREC + 1;
  localparam int MAX_CODE  = 2**ADC_PREC - 1;
  localparam logic [CW-1:0] LAST_CHAN = CW'(OUT_PAR - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_EMIT  = 2'd3;

  function automatic logic [31:0] quantise(input logic [ACC_WIDTH-1:0] val);
    logic [ACC_WIDTH-1:0] code;
    logic [31:0]          res;
    code = val >> SHIFT;
    res  = 32'd0;
    if (code > ACC_WIDTH'(MAX_CODE)) begin
      res[ADC_PREC-1:0] = {ADC_PREC{1'b1}};
    end else begin
      res[ADC_PREC-1:0] = code[ADC_PREC-1:0];
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0]     mem_q [RAM_DEPTH];

  logic [1:0]                state_q, state_d;
  logic [LEN_WIDTH-1:0]      remaining_q, remaining_d;
  logic [RW-1:0]             row_q, row_d;
  logic                      drain_q, drain_d;
  logic [CW-1:0]             chan_q, chan_d;
  logic                      out_valid_q, out_valid_d;
  logic [31:0]               out_data_q, out_data_d;

  logic                      s1_valid_q;
  logic [IN_PAR*IN_PREC-1:0] s1_data_q;
  logic [RW-1:0]             s1_row_q;
  logic                      s2_valid_q;
  logic [PSUM_W-1:0]         psum_q [OUT_PAR];
  logic [PSUM_W-1:0]         psum_d [OUT_PAR];
  logic [ACC_WIDTH-1:0]      acc_q  [OUT_PAR];
  logic [ACC_WIDTH-1:0]      acc_d  [OUT_PAR];

  logic wr_fire;
  logic start_fire;
  logic in_fire;
  logic out_fire;

  assign wr_ready_o    = (state_q == ST_IDLE);
  assign start_ready_o = (state_q == ST_IDLE);
  assign in_ready_o    = (state_q == ST_RUN) && (remaining_q != '0);
  assign busy_o        = (state_q != ST_IDLE);
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_chan_o    = chan_q;
  assign out_last_o    = (chan_q == LAST_CHAN);

  assign wr_fire    = wr_valid_i & wr_ready_o;
  assign start_fire = start_valid_i & start_ready_o;
  assign in_fire    = in_valid_i & in_ready_o;
  assign out_fire   = out_valid_q & out_ready_i;

  // Weight store: four big-endian bytes per write, wrapping modulo RAM_DEPTH; never reset.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      for (int k = 0; k < 4; k++) begin
        mem_q[wr_addr_i + ADDR_WIDTH'(k)] <= DATA_WIDTH'(wr_data_i[31-8*k -: 8]);
      end
    end
  end

  // Per-bank dot product of the staged vector against IN_PAR consecutive rows (wrapping in bank).
  always_comb begin
    for (int b = 0; b < OUT_PAR; b++) begin
      logic [PSUM_W-1:0] sum;
      sum = '0;
      for (int j = 0; j < IN_PAR; j++) begin
        sum = sum + PSUM_W'(s1_data_q[(IN_PAR-j)*IN_PREC-1 -: IN_PREC])
                  * PSUM_W'(mem_q[{CW'(b), RW'(s1_row_q + RW'(j))}]);
      end
      psum_d[b] = sum;
    end
  end

  // Accumulators clear on job start and absorb the registered partial sums.
  always_comb begin
    for (int b = 0; b < OUT_PAR; b++) begin
      if (start_fire) begin
        acc_d[b] = '0;
      end else if (s2_valid_q) begin
        acc_d[b] = acc_q[b] + ACC_WIDTH'(psum_q[b]);
      end else begin
        acc_d[b] = acc_q[b];
      end
    end
  end

  // Sequencer: RUN consumes vectors, DRAIN lets the two pipeline stages settle, EMIT streams codes.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    row_d       = row_q;
    drain_d     = drain_q;
    chan_d      = chan_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start_fire) begin
          state_d     = ST_RUN;
          remaining_d = start_len_i;
          row_d       = start_base_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (remaining_q == '0) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end else if (in_fire) begin
          remaining_d = remaining_q - LEN_WIDTH'(1);
          row_d       = row_q + RW'(IN_PAR);
          if (remaining_q == LEN_WIDTH'(1)) begin
            state_d = ST_DRAIN;
            drain_d = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_q) begin
          state_d = ST_EMIT;
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_EMIT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = quantise(acc_q[chan_q]);
        end else if (out_fire) begin
          if (chan_q == LAST_CHAN) begin
            out_valid_d = 1'b0;
            chan_d      = '0;
            state_d     = ST_IDLE;
          end else begin
            chan_d     = chan_q + CW'(1);
            out_data_d = quantise(acc_q[chan_q + CW'(1)]);
          end
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      row_q       <= '0;
      drain_q     <= 1'b0;
      chan_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      row_q       <= row_d;
      drain_q     <= drain_d;
      chan_q      <= chan_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Input staging, partial-sum register and accumulators.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_row_q   <= '0;
      s2_valid_q <= 1'b0;
      for (int b = 0; b < OUT_PAR; b++) begin
        psum_q[b] <= '0;
        acc_q[b]  <= '0;
      end
    end else begin
      s1_valid_q <= in_fire;
      s1_data_q  <= in_data_i;
      s1_row_q   <= row_q;
      s2_valid_q <= s1_valid_q;
      for (int b = 0; b < OUT_PAR; b++) begin
        psum_q[b] <= psum_d[b];
        acc_q[b]  <= acc_d[b];
      end
    end
  end

endmodule

// File: tb/tb_cim_gemm_engine.sv
// Self-checking bench for cim_gemm_engine: directed scenarios plus randomized jobs scored
// against a byte-array weight model and plain-arithmetic dot products.
module tb_cim_gemm_engine;

  localparam int RAM_DEPTH = 1024;
  localparam int ROW_DEPTH = 128;
  localparam int NCH       = 8;
  localparam int NLANE     = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start_valid;
  logic        start_ready;
  logic [6:0]  start_base;
  logic [7:0]  start_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_chan;
  logic        out_last;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0]  mem_m [RAM_DEPTH];
  logic [31:0] vecs [$];
  logic [31:0] exp_code [NCH];
  logic [31:0] got_code [NCH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cim_gemm_engine dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .start_valid_i(start_valid), .start_ready_o(start_ready),
    .start_base_i(start_base), .start_len_i(start_len),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_chan_o(out_chan), .out_last_o(out_last), .busy_o(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic model_write(input int addr, input logic [31:0] data);
    for (int k = 0; k < 4; k++) mem_m[(addr + k) % RAM_DEPTH] = data[31-8*k -: 8];
  endtask

  task automatic write_word(input int addr, input logic [31:0] data);
    int n;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = 10'(addr);
    wr_data  = data;
    n = 0;
    while (!wr_ready && n < 50) begin @(negedge clk); n++; end
    if (!wr_ready) check("wr_ready_timeout", {31'd0, wr_ready}, 32'd1);
    @(posedge clk);
    model_write(addr, data);
    #1 wr_valid = 1'b0;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < RAM_DEPTH; a += 4) write_word(a, 32'd0);
  endtask

  task automatic start_job(input int base, input int len, input bit ww, input int waddr,
                           input logic [31:0] wdata);
    int n;
    @(negedge clk);
    start_valid = 1'b1;
    start_base  = 7'(base);
    start_len   = 8'(len);
    if (ww) begin
      wr_valid = 1'b1;
      wr_addr  = 10'(waddr);
      wr_data  = wdata;
    end
    n = 0;
    while (!start_ready && n < 50) begin @(negedge clk); n++; end
    if (!start_ready) check("start_ready_timeout", {31'd0, start_ready}, 32'd1);
    @(posedge clk);
    if (ww) model_write(waddr, wdata);
    #1 start_valid = 1'b0;
    wr_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [31:0] v);
    int n;
    @(negedge clk);
    if ($urandom_range(0, 3) == 0) @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_data = $urandom();
  endtask

  // Expected code per channel straight from the dot-product definition.
  task automatic compute_expected(input int base, input int len);
    logic [31:0] acc;
    logic [31:0] lane;
    for (int b = 0; b < NCH; b++) begin
      acc = 32'd0;
      for (int i = 0; i < len; i++) begin
        for (int j = 0; j < NLANE; j++) begin
          lane = (vecs[i] >> ((NLANE - 1 - j) * 4)) & 32'hF;
          acc  = acc + lane * 32'(mem_m[b*ROW_DEPTH + ((base + i*NLANE + j) % ROW_DEPTH)]);
        end
      end
      exp_code[b] = ((acc >> 8) > 32'd63) ? 32'd63 : (acc >> 8);
    end
  endtask

  task automatic run_job(input int base, input int len, input int stall_k, input bit ww,
                         input int waddr, input logic [31:0] wdata);
    int n;
    int hs_cyc;
    start_job(base, len, ww, waddr, wdata);
    compute_expected(base, len);
    @(negedge clk);
    check("start_ready_busy", {31'd0, start_ready}, 32'd0);
    check("busy_in_job", {31'd0, busy}, 32'd1);
    for (int i = 0; i < len; i++) send_vec(vecs[i]);
    @(negedge clk);
    hs_cyc = cyc;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    if (len > 0) check("first_out_latency", 32'(cyc - hs_cyc), 32'd3);
    for (int k = 0; k < NCH; k++) begin
      n = 0;
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      if (!out_valid) check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
      if (k == stall_k) begin
        repeat (5) begin
          @(negedge clk);
          check("stall_valid", {31'd0, out_valid}, 32'd1);
          check("stall_chan", {29'd0, out_chan}, 32'(k));
          check("stall_data", out_data, exp_code[k]);
        end
      end
      got_code[k] = out_data;
      check("out_chan", {29'd0, out_chan}, 32'(k));
      check("out_data", out_data, exp_code[k]);
      check("out_last", {31'd0, out_last}, (k == NCH - 1) ? 32'd1 : 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
    end
    check("valid_after_last", {31'd0, out_valid}, 32'd0);
    check("busy_after_last", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    start_valid = 1'b0; start_base = '0; start_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_chan", {29'd0, out_chan}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("rst_start_ready", {31'd0, start_ready}, 32'd1);
    rst_n = 1'b1;

    // Inputs offered while idle are refused.
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;

    clear_mem();

    // Test 1: bank0 bytes 0..7 = 0x10, one all-ones vector.
    write_word(0, 32'h10101010);
    write_word(4, 32'h10101010);
    vecs = {32'hFFFFFFFF};
    run_job(0, 1, -1, 1'b0, 0, 32'd0);
    check("t1_chan0", got_code[0], 32'd7);
    check("t1_chan5", got_code[5], 32'd0);

    // Test 2: saturation.
    write_word(0, 32'hFFFFFFFF);
    write_word(4, 32'hFFFFFFFF);
    run_job(0, 1, -1, 1'b0, 0, 32'd0);
    check("t2_chan0_clamp", got_code[0], 32'd63);

    // Test 3: three vectors; last weight word written in the same cycle as start.
    write_word(0, 32'h10101010);
    write_word(4, 32'h10101010);
    write_word(8, 32'h10101010);
    write_word(12, 32'h10101010);
    write_word(16, 32'h10101010);
    vecs = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    run_job(0, 3, -1, 1'b1, 20, 32'h10101010);
    check("t3_chan0", got_code[0], 32'd22);

    // Test 4: row wrap within bank 0.
    for (int a = 0; a < 24; a += 4) write_word(a, 32'd0);
    write_word(124, 32'h10101010);
    write_word(0, 32'h10101010);
    vecs = {32'hFFFFFFFF};
    run_job(124, 1, -1, 1'b0, 0, 32'd0);
    check("t4_chan0_wrap", got_code[0], 32'd7);

    // Test 5: empty job with back-pressure mid-stream.
    vecs.delete();
    run_job(0, 0, 3, 1'b0, 0, 32'd0);
    check("t5_chan3", got_code[3], 32'd0);

    // Test 6: reset in the middle of a job.
    start_job(0, 3, 1'b0, 0, 32'd0);
    send_vec(32'hFFFFFFFF);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_start_ready", {31'd0, start_ready}, 32'd1);
    repeat (6) begin
      @(negedge clk);
      check("t6_no_output", {31'd0, out_valid}, 32'd0);
    end
    write_word(124, 32'd0);
    write_word(0, 32'h10101010);
    write_word(4, 32'h10101010);
    vecs = {32'hFFFFFFFF};
    run_job(0, 1, -1, 1'b0, 0, 32'd0);
    check("t6_rerun_chan0", got_code[0], 32'd7);

    // Randomized jobs against the model.
    for (int r = 0; r < 6; r++) begin
      int len;
      repeat (60) write_word($urandom_range(0, RAM_DEPTH - 1), $urandom() & 32'h3F3F3F3F);
      vecs.delete();
      len = $urandom_range(0, 4);
      for (int i = 0; i < len; i++) vecs.push_back($urandom());
      run_job($urandom_range(0, ROW_DEPTH - 1), len, $urandom_range(0, 8),
              1'($urandom_range(0, 1)), $urandom_range(0, RAM_DEPTH - 1), $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
